// File: rtl/aes_subshift_serial_if.sv
// Valid/ready stream bundle for the SubBytes+ShiftRows stage: state in from
// AddRoundKey, substituted and row-shifted state out to MixColumns.
interface aes_subshift_serial_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;

  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );

  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );
endinterface

// File: rtl/aes_subshift_serial.sv
// Byte-serial AES SubBytes + ShiftRows: streams the 16 state bytes in ShiftRows
// order through an external (shared) S-box and rebuilds the result in place.
module aes_subshift_serial #(
  parameter int SBOX_LAT = 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  aes_subshift_serial_if.slave  bus,
  output logic [7:0]            sbox_a,
  input  logic [7:0]            sbox_d,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [127:0]        in_buf_p0;
  logic [127:0]        out_state_p1;
  logic [3:0]          issue_cnt;
  logic                issue_done;
  logic [4:0]          cap_cnt;
  logic [SBOX_LAT-1:0] vld_p;
  logic                accept;
  logic                issue;
  logic                capture;

  // Output byte k = 4c + r comes from input byte 4*((c + r) mod 4) + r;
  // the 2-bit column sum wraps naturally.
  function automatic logic [3:0] src_idx(input logic [3:0] k);
    logic [1:0] col;
    col = k[3:2] + k[1:0];
    return {col, k[1:0]};
  endfunction

  function automatic logic [7:0] byte_of(input logic [127:0] s, input logic [3:0] n);
    return s[8*(15-n) +: 8];
  endfunction

  assign accept  = (state == IDLE) && bus.in_valid;
  assign issue   = (state == RUN) && !issue_done;
  assign capture = (state == RUN) && vld_p[SBOX_LAT-1];

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_state = out_state_p1;
  assign busy          = (state == RUN);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = RUN;
      RUN:     if (capture && (cap_cnt == 5'd15)) state_nxt = DONE;
      DONE:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: input buffer, loaded only on the accepting edge
  always_ff @(posedge Clk) begin
    if (accept) in_buf_p0 <= bus.in_state;
  end

  // Stage p1: issue to the S-box, then capture SBOX_LAT cycles later
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state        <= IDLE;
      issue_cnt    <= '0;
      issue_done   <= 1'b0;
      cap_cnt      <= '0;
      vld_p        <= '0;
      sbox_a       <= '0;
      out_state_p1 <= '0;
    end else begin
      state    <= state_nxt;
      vld_p[0] <= issue;
      for (int i = 1; i < SBOX_LAT; i++) vld_p[i] <= vld_p[i-1];

      if (accept) begin
        issue_cnt  <= '0;
        issue_done <= 1'b0;
        cap_cnt    <= '0;
      end

      if (issue) begin
        sbox_a <= byte_of(in_buf_p0, src_idx(issue_cnt));
        // Counter parks at 15 rather than wrapping; the flag ends issuing.
        if (issue_cnt == 4'd15) issue_done <= 1'b1;
        else                    issue_cnt  <= issue_cnt + 4'd1;
      end

      if (capture) begin
        out_state_p1[8*(15-cap_cnt[3:0]) +: 8] <= sbox_d;
        cap_cnt <= cap_cnt + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_aes_subshift_serial.sv
// Scoreboard bench for aes_subshift_serial: three instances (S-box latency 1, 2, 4)
// each fed by a bench S-box model; expected states come from a reference model.
module tb_aes_subshift_serial;

  localparam logic [2047:0] SBOX_HEX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  localparam logic [127:0] APPB_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] APPB_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] RAMP_IN  = 128'h000102030405060708090a0b0c0d0e0f;

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX_HEX[8*(255-int'(x)) +: 8];
  endfunction

  function automatic logic [127:0] ref_model(input logic [127:0] s);
    logic [127:0] o;
    int r, c, src;
    o = '0;
    for (int k = 0; k < 16; k++) begin
      r = k % 4;
      c = k / 4;
      src = 4 * ((c + r) % 4) + r;
      o[127-8*k -: 8] = sb(s[127-8*src -: 8]);
    end
    return o;
  endfunction

  logic         Clk;
  logic         Rst_n;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] in_state  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] out_state [3];
  logic [7:0]   sbox_a    [3];
  logic [7:0]   sbox_d    [3];
  logic         busy      [3];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [127:0] exp_q[$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  always @(posedge Clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 2 : 4;
    aes_subshift_serial_if bus ();

    assign bus.in_valid  = in_valid[g];
    assign bus.in_state  = in_state[g];
    assign bus.out_ready = out_ready[g];
    assign in_ready[g]   = bus.in_ready;
    assign out_valid[g]  = bus.out_valid;
    assign out_state[g]  = bus.out_state;

    if (LAT == 1) begin : g_l1
      assign sbox_d[g] = sb(sbox_a[g]);
    end else begin : g_ln
      logic [7:0] a_dly [LAT-1];
      always @(posedge Clk) begin
        a_dly[0] <= sbox_a[g];
        for (int i = 1; i < LAT-1; i++) a_dly[i] <= a_dly[i-1];
      end
      assign sbox_d[g] = sb(a_dly[LAT-2]);
    end

    aes_subshift_serial #(.SBOX_LAT(LAT)) dut (
      .Clk    (Clk),
      .Rst_n  (Rst_n),
      .bus    (bus),
      .sbox_a (sbox_a[g]),
      .sbox_d (sbox_d[g]),
      .busy   (busy[g])
    );
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input int g, input logic [127:0] s, output int t_acc);
    int n = 0;
    in_state[g] = s;
    in_valid[g] = 1'b1;
    while (!in_ready[g] && n < 200) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!in_ready[g]) begin
      errors++;
      $display("FAIL send_timeout[%0d]: in_ready=%b required 1", g, in_ready[g]);
      in_valid[g] = 1'b0;
      t_acc = cyc;
      return;
    end
    exp_q.push_back(ref_model(s));
    @(negedge Clk);
    t_acc = cyc;
    in_valid[g] = 1'b0;
  endtask

  task automatic recv(input int g, input int t_acc, input int lat, input string nm,
                      output logic [127:0] got);
    int n = 0;
    logic [127:0] exp;
    got = '0;
    while (!out_valid[g] && n < 200) begin
      @(negedge Clk);
      n++;
    end
    checks++;
    if (!out_valid[g]) begin
      errors++;
      $display("FAIL %s_timeout: out_valid=%b required 1", nm, out_valid[g]);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    checks++;
    if (cyc !== t_acc + 16 + lat) begin
      errors++;
      $display("FAIL %s_latency: out_valid after %0d cycles, required %0d", nm, cyc - t_acc, 16 + lat);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    checks++;
    if (out_state[g] !== exp) begin
      errors++;
      $display("FAIL %s_data: got %h required %h", nm, out_state[g], exp);
    end
    got = out_state[g];
    if (out_ready[g]) @(negedge Clk);
  endtask

  task automatic test_reset;
    Rst_n = 1'b1;
    for (int g = 0; g < 3; g++) begin
      in_valid[g]  = 1'b0;
      in_state[g]  = '0;
      out_ready[g] = 1'b1;
    end
    #1 Rst_n = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b required 0", out_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", busy[0]); end
    checks++; if (out_state[0] !== 128'h0) begin errors++; $display("FAIL rst_out_state: got %h required 0", out_state[0]); end
    checks++; if (sbox_a[0] !== 8'h00) begin errors++; $display("FAIL rst_sbox_a: got %h required 00", sbox_a[0]); end
    Rst_n = 1'b1;
    @(negedge Clk);
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b required 1", in_ready[0]); end
  endtask

  task automatic test_fips;
    int t;
    logic [127:0] got;
    send(0, APPB_IN, t);
    recv(0, t, 1, "fips", got);
    checks++;
    if (got !== APPB_OUT) begin errors++; $display("FAIL fips_vector: got %h required %h", got, APPB_OUT); end
    checks++;
    if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL fips_ready_after: got %b required 1", in_ready[0]); end
  endtask

  task automatic test_constants;
    int t;
    logic [127:0] got;
    send(0, {16{8'h00}}, t);
    recv(0, t, 1, "zeros", got);
    checks++;
    if (got !== {16{8'h63}}) begin errors++; $display("FAIL zeros_vector: got %h required %h", got, {16{8'h63}}); end
    send(0, {16{8'hff}}, t);
    recv(0, t, 1, "ones", got);
    checks++;
    if (got !== {16{8'h16}}) begin errors++; $display("FAIL ones_vector: got %h required %h", got, {16{8'h16}}); end
    send(0, RAMP_IN, t);
    recv(0, t, 1, "ramp", got);
    checks++;
    if (got[127:120] !== 8'h63) begin errors++; $display("FAIL ramp_byte0: got %h required 63", got[127:120]); end
    checks++;
    if (got[119:112] !== 8'h6b) begin errors++; $display("FAIL ramp_byte1: got %h required 6b", got[119:112]); end
  endtask

  task automatic test_latency;
    int t;
    logic [127:0] got;
    for (int g = 1; g < 3; g++) begin
      send(g, APPB_IN, t);
      recv(g, t, (g == 1) ? 2 : 4, "latency", got);
      checks++;
      if (got !== APPB_OUT) begin errors++; $display("FAIL latency_vector[%0d]: got %h required %h", g, got, APPB_OUT); end
    end
  endtask

  task automatic test_backpressure;
    int t;
    logic [127:0] got, second, held;
    second = {$urandom, $urandom, $urandom, $urandom};
    held = ref_model(APPB_IN);
    out_ready[0] = 1'b0;
    send(0, APPB_IN, t);
    recv(0, t, 1, "bp_first", got);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_state[0] = second;
        in_valid[0] = 1'b1;
      end else begin
        in_valid[0] = 1'b0;
      end
      @(negedge Clk);
      checks++; if (out_state[0] !== held) begin errors++; $display("FAIL bp_stable: got %h required %h", out_state[0], held); end
      checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b required 1", out_valid[0]); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", in_ready[0]); end
    end
    in_valid[0] = 1'b0;
    out_ready[0] = 1'b1;
    @(negedge Clk);
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL bp_ready_after: got %b required 1", in_ready[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL bp_not_captured: busy=%b required 0", busy[0]); end
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b required 0", out_valid[0]); end
    send(0, second, t);
    recv(0, t, 1, "bp_second", got);
  endtask

  task automatic test_reset_abort;
    int t;
    logic [127:0] got;
    send(0, APPB_IN, t);
    repeat (7) @(negedge Clk);
    @(posedge Clk);
    Rst_n = 1'b0;
    #1;
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("FAIL abort_out_valid: got %b required 0", out_valid[0]); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b required 0", busy[0]); end
    checks++; if (out_state[0] !== 128'h0) begin errors++; $display("FAIL abort_out_state: got %h required 0", out_state[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("FAIL abort_in_ready: got %b required 1", in_ready[0]); end
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    send(0, APPB_IN, t);
    recv(0, t, 1, "abort_next", got);
    checks++;
    if (got !== APPB_OUT) begin errors++; $display("FAIL abort_vector: got %h required %h", got, APPB_OUT); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] vec [3];
    logic [127:0] exp;
    int t_out [3];
    int n_in = 0;
    int n_out = 0;
    vec[0] = APPB_IN;
    vec[1] = RAMP_IN;
    vec[2] = {$urandom, $urandom, $urandom, $urandom};
    out_ready[0] = 1'b1;
    in_state[0] = vec[0];
    in_valid[0] = 1'b1;
    for (int i = 0; i < 200 && n_out < 3; i++) begin
      if (out_valid[0]) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        checks++;
        if (out_state[0] !== exp) begin errors++; $display("FAIL b2b_data%0d: got %h required %h", n_out, out_state[0], exp); end
        t_out[n_out] = cyc;
        n_out++;
      end
      if (in_valid[0] && in_ready[0]) begin
        exp_q.push_back(ref_model(in_state[0]));
        n_in++;
      end
      @(negedge Clk);
      if (n_in >= 3) in_valid[0] = 1'b0;
      else           in_state[0] = vec[n_in];
    end
    in_valid[0] = 1'b0;
    checks++;
    if (n_out != 3) begin
      errors++;
      $display("FAIL b2b_count: got %0d results required 3", n_out);
    end else begin
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (t_out[k] - t_out[k-1] != 19) begin
          errors++;
          $display("FAIL b2b_spacing%0d: got %0d cycles required 19", k, t_out[k] - t_out[k-1]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_constants();
    test_latency();
    test_backpressure();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
